// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } arb_port_t;

  // Chooses the port to serve. A lone requester always wins. When both ports
  // ask, the port that did not get the previous grant goes first.
  function automatic arb_port_t pick_port(input logic if_req, input logic dm_req,
                                          input arb_port_t last_grant);
    if (if_req && dm_req) begin
      return (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
    end else if (dm_req) begin
      return PORT_DM;
    end else begin
      return PORT_IF;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the CPU ports, the arbiter and the memory macro.
// The master side is the environment: the CPU drives requests and the memory
// drives read data. The slave side is the arbiter.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_re;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_lat_ctr.sv
// Loadable down-counter that times the fixed memory latency.
module mem_lat_ctr
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] count;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LAT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between instruction fetch and data access,
// one access at a time, and stalls the core while a request is outstanding.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  arb_port_t     grant;
  arb_port_t     last_grant;
  arb_port_t     pick;
  logic          dm_req;
  logic          start;
  logic          capture;
  logic          ctr_zero;
  logic          ctr_dec;

  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  assign dm_req  = bus.dm_re | bus.dm_we;
  assign start   = (state == ST_IDLE) && (bus.if_req || dm_req);
  assign capture = (state == ST_WAIT) && ctr_zero;
  assign ctr_dec = (state == ST_ISSUE) || (state == ST_WAIT);
  assign pick    = pick_port(bus.if_req, dm_req, last_grant);

  mem_lat_ctr u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (LAT_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // Next-state decode; requests only matter in IDLE, so DONE always returns there.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.if_req || dm_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ctr_zero) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winning request so the memory side sees stable values for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= PORT_IF;
      last_grant  <= PORT_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (start) begin
      grant      <= pick;
      last_grant <= pick;
      if (pick == PORT_DM) begin
        mem_we_q    <= bus.dm_we;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
      end else begin
        mem_we_q   <= 1'b0;
        mem_addr_q <= bus.if_addr;
      end
    end
  end

  // Capture read data into the granted port's register; writes leave both untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (capture && !mem_we_q) begin
      if (grant == PORT_IF) begin
        if_rdata_q <= bus.mem_rdata;
      end else begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state == ST_ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_ack    = (state == ST_DONE) && (grant == PORT_IF);
  assign bus.dm_ack    = (state == ST_DONE) && (grant == PORT_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (dm_req & ~bus.dm_ack);

endmodule
